// File: rtl/or_crossbar_pipe.sv
// ---------------------------------------------------------------------------
// or_crossbar_pipe
//
// Two-stage pipelined OR crossbar with rdy/ack flow control on both sides.
// Each destination lane receives the bitwise OR of every source lane routed
// to it. The block also reports which destinations have any source routed to
// them, and which have two or more sources routed to them.
//
//   S0 registers the source beat (data plus routing matrix).
//   S1 registers the OR-reduced result.
//   The OR tree sits between the two register stages, so no combinational
//   path runs from the data inputs to the data outputs.
//
// Optional feature (macro OR_CROSSBAR_COLLISION_CNT_EN):
//   This adds a saturating counter of output transfers that carry at least
//   one multi-source hit. i_cnt_clr clears the counter. A clear takes
//   priority over an increment in the same cycle.
//
// Parameters:
//   BW      lane width
//   N_SRC   number of source lanes
//   N_DST   number of destination lanes
//   TR      0: i_routing[dst][src]   1: i_routing[src][dst]
//   CNT_BW  collision counter width (only used with the feature)
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   src_rdy/src_ack  input handshake; beat transfers when both are high
//   i_data           N_SRC source lanes
//   i_routing        routing matrix, sampled together with i_data
//   dst_rdy/dst_ack  output handshake; beat transfers when both are high
//   o_data           N_DST OR-reduced lanes
//   o_mask           dst i has at least one source routed to it
//   o_multi          dst i has two or more sources routed to it
//   i_cnt_clr        collision counter clear (feature only)
//   o_collision_cnt  collision counter (feature only)
// ---------------------------------------------------------------------------
module or_crossbar_pipe #(
  parameter int BW     = 16,
  parameter int N_SRC  = 16,
  parameter int N_DST  = 8,
  parameter int TR     = 0,
  parameter int CNT_BW = 16
) (
  input  logic                                                         i_clk,
  input  logic                                                         i_rst,
  input  logic                                                         src_rdy,
  output logic                                                         src_ack,
  input  logic [N_SRC-1:0][BW-1:0]                                     i_data,
  input  logic [(TR != 0 ? N_SRC : N_DST)-1:0][(TR != 0 ? N_DST : N_SRC)-1:0] i_routing,
  output logic                                                         dst_rdy,
  input  logic                                                         dst_ack,
  output logic [N_DST-1:0][BW-1:0]                                     o_data,
  output logic [N_DST-1:0]                                             o_mask,
  output logic [N_DST-1:0]                                             o_multi
`ifdef OR_CROSSBAR_COLLISION_CNT_EN
  ,
  input  logic                                                         i_cnt_clr,
  output logic [CNT_BW-1:0]                                            o_collision_cnt
`endif
);

  // Catch meaningless configurations at elaboration.
  if (BW < 1 || N_SRC < 1 || N_DST < 1 || CNT_BW < 1) begin : g_bad_params
    $error("or_crossbar_pipe: BW, N_SRC, N_DST and CNT_BW must all be >= 1");
  end

  // -------------------------------------------------------------------------
  // Handshake control
  // -------------------------------------------------------------------------
  logic v0;
  logic v1;
  logic adv1;    // S0 beat moves into S1 this cycle
  logic s_xfer;  // source beat accepted this cycle

  assign adv1    = v0 && (!v1 || dst_ack);
  assign src_ack = !v0 || adv1;
  assign s_xfer  = src_rdy && src_ack;
  assign dst_rdy = v1;

  // -------------------------------------------------------------------------
  // Stage 0: capture the source beat
  // -------------------------------------------------------------------------
  logic [N_SRC-1:0][BW-1:0]                                     data_q;
  logic [(TR != 0 ? N_SRC : N_DST)-1:0][(TR != 0 ? N_DST : N_SRC)-1:0] route_q;

  // NOTE: The S0 payload registers have no reset. The v0 bit gates every
  // use of them, so their contents after reset do not matter.
  always_ff @(posedge i_clk) begin
    if (s_xfer) begin
      data_q  <= i_data;
      route_q <= i_routing;
    end
  end

  // Convert the routing matrix to dst-major form, so that sel[dst][src]
  // has the same meaning whichever routing layout is configured.
  logic [N_DST-1:0][N_SRC-1:0] sel;

  if (TR != 0) begin : g_transposed
    always_comb begin
      sel = '0;
      for (int i = 0; i < N_DST; i++) begin
        for (int j = 0; j < N_SRC; j++) begin
          sel[i][j] = route_q[j][i];
        end
      end
    end
  end else begin : g_normal
    assign sel = route_q;
  end

  // -------------------------------------------------------------------------
  // OR tree and hit detection between S0 and S1
  // -------------------------------------------------------------------------
  logic [N_DST-1:0][BW-1:0] or_d;
  logic [N_DST-1:0]         mask_d;
  logic [N_DST-1:0]         multi_d;

  // NOTE: Every output of this block gets a default value first, so no
  // path through the loops can infer a latch. Blocking assignments let each
  // loop iteration see the partial result of the previous one.
  always_comb begin
    or_d    = '0;
    mask_d  = '0;
    multi_d = '0;
    for (int i = 0; i < N_DST; i++) begin
      for (int j = 0; j < N_SRC; j++) begin
        if (sel[i][j]) begin
          // A second routed source finds mask_d[i] already set.
          multi_d[i] = multi_d[i] | mask_d[i];
          mask_d[i]  = 1'b1;
          or_d[i]    = or_d[i] | data_q[j];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Valid bits and stage 1 output registers
  // -------------------------------------------------------------------------
  // NOTE: Sequential state uses only non-blocking assignments, so every
  // register samples values from before the clock edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v0      <= 1'b0;
      v1      <= 1'b0;
      o_data  <= '0;
      o_mask  <= '0;
      o_multi <= '0;
    end else begin
      if (s_xfer) begin
        v0 <= 1'b1;
      end else if (adv1) begin
        v0 <= 1'b0;
      end

      if (adv1) begin
        v1      <= 1'b1;
        o_data  <= or_d;
        o_mask  <= mask_d;
        o_multi <= multi_d;
      end else if (v1 && dst_ack) begin
        v1 <= 1'b0;
      end
    end
  end

`ifdef OR_CROSSBAR_COLLISION_CNT_EN
  // -------------------------------------------------------------------------
  // Saturating collision counter
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst || i_cnt_clr) begin
      o_collision_cnt <= '0;
    end else if (dst_rdy && dst_ack && (|o_multi) && (o_collision_cnt != '1)) begin
      o_collision_cnt <= o_collision_cnt + CNT_BW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_or_crossbar_pipe.sv
// ---------------------------------------------------------------------------
// tb_or_crossbar_pipe
//
// Directed testbench for or_crossbar_pipe. It contains two instances that
// share the stimulus: dut0 uses the dst-major routing layout (TR=0) and dut1
// uses the src-major layout (TR=1). Both use BW=8, N_SRC=4 and N_DST=2.
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_or_crossbar_pipe;

  localparam int BW = 8;
  localparam int NS = 4;
  localparam int ND = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    src_rdy;
  logic                    dst_ack;
  logic                    cnt_clr;
  logic [NS-1:0][BW-1:0]   data;
  logic [ND-1:0][NS-1:0]   rt0;
  logic [NS-1:0][ND-1:0]   rt1;

  logic                    sa0, sa1, dr0, dr1;
  logic [ND-1:0][BW-1:0]   od0, od1;
  logic [ND-1:0]           om0, om1, ox0, ox1;
  logic [CW-1:0]           cnt0, cnt1;

  or_crossbar_pipe #(.BW(BW), .N_SRC(NS), .N_DST(ND), .TR(0), .CNT_BW(CW)) dut0 (
    .i_clk(clk), .i_rst(rst), .src_rdy(src_rdy), .src_ack(sa0),
    .i_data(data), .i_routing(rt0), .dst_rdy(dr0), .dst_ack(dst_ack),
    .o_data(od0), .o_mask(om0), .o_multi(ox0)
`ifdef OR_CROSSBAR_COLLISION_CNT_EN
    , .i_cnt_clr(cnt_clr), .o_collision_cnt(cnt0)
`endif
  );

  or_crossbar_pipe #(.BW(BW), .N_SRC(NS), .N_DST(ND), .TR(1), .CNT_BW(CW)) dut1 (
    .i_clk(clk), .i_rst(rst), .src_rdy(src_rdy), .src_ack(sa1),
    .i_data(data), .i_routing(rt1), .dst_rdy(dr1), .dst_ack(dst_ack),
    .o_data(od1), .o_mask(om1), .o_multi(ox1)
`ifdef OR_CROSSBAR_COLLISION_CNT_EN
    , .i_cnt_clr(cnt_clr), .o_collision_cnt(cnt1)
`endif
  );

`ifndef OR_CROSSBAR_COLLISION_CNT_EN
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [BW-1:0] got [8];
  int n_got;
  int n_sent;
  logic [CW-1:0] cexp [5];

  initial begin
    rst = 1'b1; src_rdy = 1'b0; dst_ack = 1'b0; cnt_clr = 1'b0;
    data = '0; rt0 = '0; rt1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---- reset state ------------------------------------------------------
    check("rst_src_ack", 64'(sa0), 64'd1);
    check("rst_dst_rdy", 64'(dr0), 64'd0);
    check("rst_o_data",  64'(od0), 64'd0);
    check("rst_o_mask",  64'(om0), 64'd0);
    check("rst_o_multi", 64'(ox0), 64'd0);
`ifdef OR_CROSSBAR_COLLISION_CNT_EN
    check("rst_cnt", 64'(cnt0), 64'd0);
`endif

    // ---- basic routing for both layouts (one shared beat) -----------------
    // dut0: dst0 <- src0|src1 = 0x03, and dst1 has nothing routed to it.
    // dut1: src3 -> dst1 = 0x80, and dst0 has nothing routed to it.
    data = {8'h80, 8'h04, 8'h02, 8'h01};
    rt0[0] = 4'b0011; rt0[1] = 4'b0000;
    rt1 = '0; rt1[3] = 2'b10;
    src_rdy = 1'b1; dst_ack = 1'b1;
    @(negedge clk);
    src_rdy = 1'b0;
    check("lat_not_yet", 64'(dr0), 64'd0);
    @(negedge clk);
    check("tr0_dst_rdy", 64'(dr0), 64'd1);
    check("tr0_o_data",  64'(od0), 64'h0003);
    check("tr0_o_mask",  64'(om0), 64'b01);
    check("tr0_o_multi", 64'(ox0), 64'b01);
    check("tr1_dst_rdy", 64'(dr1), 64'd1);
    check("tr1_o_data",  64'(od1), 64'h8000);
    check("tr1_o_mask",  64'(om1), 64'b10);
    check("tr1_o_multi", 64'(ox1), 64'b00);
    @(negedge clk);
    check("drained", 64'(dr0), 64'd0);

    // ---- 8 back-to-back beats with dst_ack held high -----------------------
    rt0[0] = 4'b0001; rt0[1] = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) check("stream_gap", 64'(dr0), 64'd0);
      if (c >= 2) begin
        check("stream_rdy",  64'(dr0), 64'd1);
        check("stream_data", 64'(od0[0]), 64'(8'hA0 + c - 2));
      end
      if (c < 8) begin
        check("stream_ack", 64'(sa0), 64'd1);
        data = {8'h00, 8'h00, 8'h00, 8'(8'hA0 + c)};
        src_rdy = 1'b1;
      end else begin
        src_rdy = 1'b0;
      end
      @(negedge clk);
    end
    check("stream_end", 64'(dr0), 64'd0);

    // ---- back-pressure: 4 beats while dst_ack is low ------------------------
    dst_ack = 1'b0;
    data = {8'h00, 8'h00, 8'h00, 8'h10}; src_rdy = 1'b1;
    @(negedge clk);
    check("bp_ack_beat1", 64'(sa0), 64'd1);
    data = {8'h00, 8'h00, 8'h00, 8'h11};
    @(negedge clk);
    check("bp_ack_full",  64'(sa0), 64'd0);
    check("bp_rdy",       64'(dr0), 64'd1);
    check("bp_data",      64'(od0), 64'h0010);
    data = {8'h00, 8'h00, 8'h00, 8'h12};
    @(negedge clk);
    check("bp_ack_hold",  64'(sa0), 64'd0);
    check("bp_data_hold", 64'(od0), 64'h0010);
    check("bp_mask_hold", 64'(om0), 64'b01);
    dst_ack = 1'b1;
    n_sent = 2; n_got = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (dr0 && dst_ack && n_got < 8) begin
        got[n_got] = od0[0];
        n_got++;
      end
      if (src_rdy && sa0) n_sent++;
      @(negedge clk);
      if (n_sent < 4) begin
        data = {8'h00, 8'h00, 8'h00, 8'(8'h10 + n_sent)};
        src_rdy = 1'b1;
      end else begin
        src_rdy = 1'b0;
      end
      if (n_got >= 4 && n_sent >= 4) break;
    end
    check("bp_count", 64'(n_got), 64'd4);
    for (int k = 0; k < 4; k++) check("bp_order", 64'(got[k]), 64'(8'h10 + k));
    @(negedge clk);
    check("bp_no_dup", 64'(dr0), 64'd0);

    // ---- reset with both stages full --------------------------------------
    rt0[0] = 4'b0011;
    dst_ack = 1'b0;
    data = {8'h00, 8'h00, 8'h00, 8'h55}; src_rdy = 1'b1;
    @(negedge clk);
    data = {8'h00, 8'h00, 8'h00, 8'h66};
    @(negedge clk);
    src_rdy = 1'b0;
    check("pre_rst_full",  64'(sa0), 64'd0);
    check("pre_rst_multi", 64'(ox0), 64'b01);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy",   64'(dr0), 64'd0);
    check("mid_rst_data",  64'(od0), 64'd0);
    check("mid_rst_mask",  64'(om0), 64'd0);
    check("mid_rst_multi", 64'(ox0), 64'd0);
    check("mid_rst_ack",   64'(sa0), 64'd1);
    rst = 1'b0; dst_ack = 1'b1;
    @(negedge clk);
    check("no_ghost", 64'(dr0), 64'd0);
    data = {8'h00, 8'h00, 8'h00, 8'h77}; src_rdy = 1'b1;
    @(negedge clk);
    src_rdy = 1'b0;
    check("fresh_lat", 64'(dr0), 64'd0);
    @(negedge clk);
    check("fresh_rdy",  64'(dr0), 64'd1);
    check("fresh_data", 64'(od0), 64'h0077);
    @(negedge clk);

`ifdef OR_CROSSBAR_COLLISION_CNT_EN
    // ---- collision counter: saturation and clear priority ------------------
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("cnt_cleared", 64'(cnt0), 64'd0);
    cexp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rt0[0] = 4'b0011;
    for (int c = 0; c < 9; c++) begin
      if (c >= 3 && c <= 7) check("cnt_sat", 64'(cnt0), 64'(cexp[c-3]));
      if (c == 8) check("cnt_clr_wins", 64'(cnt0), 64'd0);
      src_rdy = (c < 6);
      data = {8'h00, 8'h00, 8'h01, 8'(8'hC0 + c)};
      cnt_clr = (c == 7);
      @(negedge clk);
    end
    cnt_clr = 1'b0; src_rdy = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/or_crossbar_pipe.md
Name: or_crossbar_pipe

Overview:
- Pipelined, flow-controlled successor of the combinational OR crossbar used in the TileAccumUnit datapath.
- Each destination lane receives the bitwise OR of every source lane routed to it. The routing matrix can be supplied in normal (dst-major) or transposed (src-major) form.
- Two register stages with rdy/ack handshakes on both sides, so the block sits between buffered producers/consumers without a timing-critical OR tree.
- Reports per-destination multi-source hits.

Parameters:
- BW, 16, bit width of one data lane
- N_SRC, 16, number of source lanes
- N_DST, 8, number of destination lanes
- TR, 0, routing layout: 0 = i_routing[dst][src]; 1 = i_routing[src][dst]
- CNT_BW, 16, width of collision counter (used only with the optional feature)

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- src_rdy  input  1  source beat valid
- src_ack  output  1  block accepts beat; transfer when src_rdy && src_ack
- i_data  input  N_SRC x BW  source lanes
- i_routing  input  (TR ? N_SRC x N_DST : N_DST x N_SRC)  routing matrix, sampled with i_data
- dst_rdy  output  1  output beat valid
- dst_ack  input  1  consumer accepts; transfer when dst_rdy && dst_ack
- o_data  output  N_DST x BW  OR-reduced destination lanes
- o_mask  output  N_DST  bit i set when any source is routed to dst i
- o_multi  output  N_DST  bit i set when two or more sources are routed to dst i
- i_cnt_clr  input  1  collision counter clear (only with feature)
- o_collision_cnt  output  CNT_BW  collision counter (only with feature)

Behaviour:
- One clock, i_clk. Reset i_rst is synchronous and active-high.
- Stage 0 (S0): registers i_data and i_routing, plus valid bit v0.
- Stage 1 (S1): computes OR/mask/multi from the S0 registers and registers o_data, o_mask, o_multi, plus valid bit v1.
- Advance conditions:
  - adv1 = v0 && (!v1 || dst_ack)
  - src_ack = !v0 || adv1 (combinational from dst_ack; no other comb path input->output)
  - dst_rdy = v1
- Valid-bit updates, each clock:
  - v0 <= (src_rdy && src_ack) ? 1 : (adv1 ? 0 : v0)
  - v1 <= adv1 ? 1 : ((v1 && dst_ack) ? 0 : v1)
- Latency: a beat accepted at cycle t is presented at dst_rdy in cycle t+2 when unstalled. Throughput is 1 beat/cycle with dst_ack held high.
- Back-pressure:
  - While dst_rdy && !dst_ack, o_data/o_mask/o_multi hold bit-exact.
  - S0 holds its beat; src_ack drops once both stages are full.
  - Data registers load only on their stage's advance; no bubbles are inserted and no beats are dropped or duplicated.
- Routing bit for (dst i, src j): TR=0 uses i_routing[i][j]; TR=1 uses i_routing[j][i].
- Lane outputs:
  - o_data[i] = OR over j of (bit ? i_data[j] : 0)
  - o_mask[i] = OR of routing bits
  - o_multi[i] = (count of routing bits) >= 2
- Zero-routing destination: o_data[i] = 0, o_mask[i] = 0, o_multi[i] = 0.
- Reset values: v0 = v1 = 0, src_ack = 1 after reset, dst_rdy = 0, o_data = 0, o_mask = 0, o_multi = 0, o_collision_cnt = 0.
- Reset mid-operation: all in-flight beats are discarded; no output beat is presented after reset until a new beat is accepted.
- Simultaneous accept and drain with both stages full and dst_ack = 1: S1 takes S0's beat, S0 takes the new beat, v0 = v1 = 1 persists.
- N_SRC != N_DST is legal in both TR modes. N_SRC = 1 or N_DST = 1 is legal; o_multi is then always 0 when N_SRC = 1.

Optional Feature:
- Macro: OR_CROSSBAR_COLLISION_CNT_EN.
- Defined:
  - i_cnt_clr and o_collision_cnt exist.
  - Counter increments by 1 on each output transfer (dst_rdy && dst_ack) whose o_multi != 0.
  - Counter saturates at 2^CNT_BW-1.
  - i_cnt_clr is synchronous; it zeroes the counter and wins over a same-cycle increment.
- Undefined: both ports are absent; no counter logic; all other behaviour is identical.

Test Plan:
- TR=0, N_SRC=4, N_DST=2, BW=8. data={0x01,0x02,0x04,0x80}, routing[0]=4'b0011, routing[1]=4'b0000, dst_ack=1 -> two cycles later: o_data={0x03,0x00}, o_mask=2'b01, o_multi=2'b01.
- TR=1, same data, routing[src3]=2'b10 and all others 0 -> o_data[1]=0x80, o_data[0]=0x00, o_mask=2'b10, o_multi=0.
- Stream 8 back-to-back beats with dst_ack=1 -> 8 outputs on 8 consecutive cycles starting at t+2, in order.
- Stream 4 beats with dst_ack=0 -> src_ack drops after 2 accepted beats and o_data holds stable. Raise dst_ack -> all 4 beats emerge in order, none lost or duplicated.
- Assert i_rst with both stages full -> next cycle dst_rdy=0 and outputs=0. A fresh beat then emerges with 2-cycle latency.
- Feature on, CNT_BW=2: send 5 beats each with a multi-hit -> counter reads 1,2,3,3,3. Assert i_cnt_clr in the same cycle as a 6th multi-hit transfer -> counter reads 0.
